uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial UART receiver, 8N1 by default. Consumes the 16x-oversample tick pulse from the baud generator.
- Samples the asynchronous rx line mid-bit and assembles LSB-first data.
- Presents each byte with a one-cycle done strobe and a framing-error flag.
- Sits between the board rx pin and the rx FIFO / consumer logic.

Parameters:
- DBIT, 8, number of data bits per frame (5..9).
- SB_TICK, 16, oversample ticks spent in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- OVS, 16, ticks per bit; must be even, >= 4.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- s_tick  input  1  one-clk-wide pulse at OVS x baud rate.
- rx  input  1  asynchronous serial line, idle high.
- dout  output  DBIT  last received data word.
- rx_done_tick  output  1  one-clk pulse when a frame completes.
- frame_err  output  1  stop bit sampled low for the frame just completed.
- busy  output  1  high while state != IDLE.

Behaviour:
- Reset values: dout=0, rx_done_tick=0, frame_err=0, busy=0, state=IDLE, counters=0, synchronizer flops=1.
- rst is sampled on posedge clk only and overrides everything.
- Reset mid-frame aborts the frame with no done pulse and returns to IDLE.
- Synchronizer: rx passes through a 2-flop synchronizer to rx_s. All decisions use rx_s, which adds 2 clk latency.
- Tick counter s: width $clog2(max(OVS,SB_TICK)); it advances only on cycles with s_tick=1.
- Bit counter n: width $clog2(DBIT).
- Shift register b: DBIT bits. The new bit enters at the MSB and b shifts right, giving LSB-first order.

State IDLE:
- If rx_s==0, go to START with s=0. No s_tick is needed to leave IDLE.

State START (on s_tick):
- If s==OVS/2-1 and rx_s==0: go to DATA with s=0, n=0.
- If s==OVS/2-1 and rx_s==1: false start. Go to IDLE; no strobe, outputs unchanged.
- Otherwise s++.

State DATA (on s_tick):
- If s==OVS-1: s=0 and b={rx_s,b[DBIT-1:1]}. If n==DBIT-1 go to STOP, else n++.
- Otherwise s++.

State STOP (on s_tick):
- If s==SB_TICK-1, set on the same edge: dout<=b, rx_done_tick<=1, frame_err<=~rx_s. Then go to IDLE if rx_s==1, else go to BRK.
- Otherwise s++.

State BRK:
- Stay until rx_s==1, then go to IDLE.
- Prevents a held-low line (break) from being re-detected as back-to-back start bits.

Output rules:
- rx_done_tick is high for exactly one clk per completed frame, including frames with frame_err=1.
- dout and frame_err hold their values until the next completion.
- Without s_tick the FSM freezes in START, DATA or STOP. Only IDLE→START and BRK→IDLE transitions are tick-independent.
- Back-to-back frames: a start bit that immediately follows a good stop is detected from IDLE on the cycle after the return.
- busy is combinational from state (state != IDLE); all other outputs are registered.

Test Plan:
- Frame 0xA5 (line 0,1,0,1,0,0,1,0,1,1), 16 ticks per bit → exactly one rx_done_tick, dout=0xA5, frame_err=0, busy low afterwards.
- rx low for 3 ticks then high (glitch) → FSM returns to IDLE at tick 7, no rx_done_tick, dout keeps its prior value.
- Frame 0x3C with stop bit driven low, line then held low for 40 ticks → rx_done_tick with dout=0x3C and frame_err=1. FSM stays in BRK (busy=1) until rx rises; no second strobe.
- Back-to-back frames 0x00 then 0xFF with no idle gap → two strobes, dout=0x00 then 0xFF, frame_err=0 for both.
- rst asserted for 1 clk during data bit 4 of 0x5A, then a clean 0x81 → first frame produces no strobe; second gives dout=0x81. All outputs read reset values on the cycle after rst.
- DBIT=7, SB_TICK=32, s_tick every 3rd clk, byte 0x55 → dout=7'h55, done strobe after 2 stop bits, frame_err=0.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1-style UART receiver driven by an OVS x baud tick.
// Ports: clk, rst (sync, active-high), s_tick (oversample pulse),
//   rx (async line, idle high) -> dout (last word),
//   rx_done_tick (1-clk strobe), frame_err (stop sampled low),
//   busy (state != IDLE).
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int OVS     = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            busy
);

    localparam int SMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
    localparam int SW   = $clog2(SMAX);
    localparam int NW   = $clog2(DBIT);

    localparam logic [SW-1:0] S_HALF = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] S_BIT  = SW'(OVS - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BRK
    } state_t;

    state_t            r_state;
    logic [1:0]        r_sync;
    logic [SW-1:0]     r_s;
    logic [NW-1:0]     r_n;
    logic [DBIT-1:0]   r_b;
    logic [DBIT-1:0]   r_dout;
    logic              r_done;
    logic              r_ferr;
    logic              w_rx_s;

    assign w_rx_s       = r_sync[1];
    assign dout         = r_dout;
    assign rx_done_tick = r_done;
    assign frame_err    = r_ferr;
    assign busy         = (r_state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sync  <= 2'b11;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
            r_dout  <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], rx};
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= ST_START;
                        r_s     <= '0;
                    end
                end
                ST_START: begin
                    if (s_tick) begin
                        if (r_s == S_HALF) begin
                            // Mid start bit: a high line here was a glitch.
                            if (!w_rx_s) begin
                                r_state <= ST_DATA;
                                r_s     <= '0;
                                r_n     <= '0;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_s <= r_s + SW'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (s_tick) begin
                        if (r_s == S_BIT) begin
                            r_s <= '0;
                            r_b <= {w_rx_s, r_b[DBIT-1:1]};
                            if (r_n == N_LAST) begin
                                r_state <= ST_STOP;
                            end else begin
                                r_n <= r_n + NW'(1);
                            end
                        end else begin
                            r_s <= r_s + SW'(1);
                        end
                    end
                end
                ST_STOP: begin
                    if (s_tick) begin
                        if (r_s == S_STOP) begin
                            r_dout  <= r_b;
                            r_done  <= 1'b1;
                            r_ferr  <= ~w_rx_s;
                            // A low stop means break: wait for the line
                            // to rise before hunting for a new start.
                            r_state <= w_rx_s ? ST_IDLE : ST_BRK;
                        end else begin
                            r_s <= r_s + SW'(1);
                        end
                    end
                end
                ST_BRK: begin
                    if (w_rx_s) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx.
// Instance a: 8N1, tick every 2 clk; instance b: 7 bits, 2 stop, tick every 3 clk.
module tb_uart_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic       tick_a = 1'b0;
    logic       tick_b = 1'b0;
    int         cnt_a = 0;
    int         cnt_b = 0;

    logic [7:0] dout_a;
    logic       done_a, ferr_a, busy_a;
    logic [6:0] dout_b;
    logic       done_b, ferr_b, busy_b;

    int errors = 0;
    int checks = 0;

    logic [7:0] qa[$];
    logic       fa[$];
    logic [6:0] qb[$];
    logic       fb[$];

    uart_rx #(.DBIT(8), .SB_TICK(16), .OVS(16)) u_a (
        .clk(clk), .rst(rst), .s_tick(tick_a), .rx(rx_a),
        .dout(dout_a), .rx_done_tick(done_a),
        .frame_err(ferr_a), .busy(busy_a)
    );

    uart_rx #(.DBIT(7), .SB_TICK(32), .OVS(16)) u_b (
        .clk(clk), .rst(rst), .s_tick(tick_b), .rx(rx_b),
        .dout(dout_b), .rx_done_tick(done_b),
        .frame_err(ferr_b), .busy(busy_b)
    );

    always @(posedge clk) begin
        tick_a <= (cnt_a == 1);
        cnt_a  <= (cnt_a == 1) ? 0 : cnt_a + 1;
        tick_b <= (cnt_b == 2);
        cnt_b  <= (cnt_b == 2) ? 0 : cnt_b + 1;
    end

    always @(negedge clk) begin
        if (done_a) begin
            qa.push_back(dout_a);
            fa.push_back(ferr_a);
        end
        if (done_b) begin
            qb.push_back(dout_b);
            fb.push_back(ferr_b);
        end
    end

    task automatic wait_ticks(input bit sel, input int k);
        for (int i = 0; i < k; i++) begin
            do @(posedge clk); while (!(sel ? tick_b : tick_a));
        end
    endtask

    task automatic send_bit(input bit sel, input logic v, input int k);
        #1;
        if (sel) rx_b = v;
        else     rx_a = v;
        wait_ticks(sel, k);
    endtask

    task automatic send_frame(input bit sel, input logic [8:0] d,
                              input int nb, input logic stopv,
                              input int stk);
        send_bit(sel, 1'b0, 16);
        for (int i = 0; i < nb; i++) send_bit(sel, d[i], 16);
        send_bit(sel, stopv, stk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (dout_a !== 8'h00) begin errors++;
            $display("FAIL reset_dout_a got=%h exp=00", dout_a); end
        checks++; if (done_a !== 1'b0) begin errors++;
            $display("FAIL reset_done_a got=%b exp=0", done_a); end
        checks++; if (ferr_a !== 1'b0) begin errors++;
            $display("FAIL reset_ferr_a got=%b exp=0", ferr_a); end
        checks++; if (busy_a !== 1'b0) begin errors++;
            $display("FAIL reset_busy_a got=%b exp=0", busy_a); end
        checks++; if (dout_b !== 7'h00 || busy_b !== 1'b0) begin errors++;
            $display("FAIL reset_b got=%h/%b exp=00/0", dout_b, busy_b); end
    endtask

    task automatic test_frame_a5;
        logic [7:0] d;
        logic       f;
        qa.delete(); fa.delete();
        send_frame(1'b0, 9'h0A5, 8, 1'b1, 16);
        send_bit(1'b0, 1'b1, 8);
        @(negedge clk);
        d = (qa.size() > 0) ? qa[0] : 8'hxx;
        f = (fa.size() > 0) ? fa[0] : 1'bx;
        checks++; if (qa.size() != 1) begin errors++;
            $display("FAIL a5_strobes got=%0d exp=1", qa.size()); end
        checks++; if (d !== 8'hA5) begin errors++;
            $display("FAIL a5_dout got=%h exp=a5", d); end
        checks++; if (f !== 1'b0) begin errors++;
            $display("FAIL a5_ferr got=%b exp=0", f); end
        checks++; if (busy_a !== 1'b0) begin errors++;
            $display("FAIL a5_busy got=%b exp=0", busy_a); end
    endtask

    task automatic test_glitch;
        qa.delete(); fa.delete();
        send_bit(1'b0, 1'b0, 3);
        @(negedge clk);
        checks++; if (busy_a !== 1'b1) begin errors++;
            $display("FAIL glitch_start_busy got=%b exp=1", busy_a); end
        send_bit(1'b0, 1'b1, 12);
        @(negedge clk);
        checks++; if (busy_a !== 1'b0) begin errors++;
            $display("FAIL glitch_busy got=%b exp=0", busy_a); end
        checks++; if (qa.size() != 0) begin errors++;
            $display("FAIL glitch_strobes got=%0d exp=0", qa.size()); end
        checks++; if (dout_a !== 8'hA5) begin errors++;
            $display("FAIL glitch_dout got=%h exp=a5", dout_a); end
    endtask

    task automatic test_break;
        logic [7:0] d;
        logic       f;
        qa.delete(); fa.delete();
        send_frame(1'b0, 9'h03C, 8, 1'b0, 16);
        send_bit(1'b0, 1'b0, 40);
        @(negedge clk);
        d = (qa.size() > 0) ? qa[0] : 8'hxx;
        f = (fa.size() > 0) ? fa[0] : 1'bx;
        checks++; if (qa.size() != 1) begin errors++;
            $display("FAIL brk_strobes got=%0d exp=1", qa.size()); end
        checks++; if (d !== 8'h3C) begin errors++;
            $display("FAIL brk_dout got=%h exp=3c", d); end
        checks++; if (f !== 1'b1) begin errors++;
            $display("FAIL brk_ferr got=%b exp=1", f); end
        checks++; if (busy_a !== 1'b1) begin errors++;
            $display("FAIL brk_busy_held got=%b exp=1", busy_a); end
        send_bit(1'b0, 1'b1, 6);
        @(negedge clk);
        checks++; if (busy_a !== 1'b0) begin errors++;
            $display("FAIL brk_busy_release got=%b exp=0", busy_a); end
        checks++; if (qa.size() != 1) begin errors++;
            $display("FAIL brk_second_strobe got=%0d exp=1", qa.size()); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] d0, d1;
        logic       f0, f1;
        qa.delete(); fa.delete();
        send_frame(1'b0, 9'h000, 8, 1'b1, 16);
        send_frame(1'b0, 9'h0FF, 8, 1'b1, 16);
        send_bit(1'b0, 1'b1, 8);
        @(negedge clk);
        d0 = (qa.size() > 0) ? qa[0] : 8'hxx;
        d1 = (qa.size() > 1) ? qa[1] : 8'hxx;
        f0 = (fa.size() > 0) ? fa[0] : 1'bx;
        f1 = (fa.size() > 1) ? fa[1] : 1'bx;
        checks++; if (qa.size() != 2) begin errors++;
            $display("FAIL b2b_strobes got=%0d exp=2", qa.size()); end
        checks++; if (d0 !== 8'h00) begin errors++;
            $display("FAIL b2b_dout0 got=%h exp=00", d0); end
        checks++; if (d1 !== 8'hFF) begin errors++;
            $display("FAIL b2b_dout1 got=%h exp=ff", d1); end
        checks++; if (f0 !== 1'b0 || f1 !== 1'b0) begin errors++;
            $display("FAIL b2b_ferr got=%b%b exp=00", f0, f1); end
    endtask

    task automatic test_reset_midframe;
        logic [7:0] v;
        logic [7:0] d;
        logic       f;
        v = 8'h5A;
        qa.delete(); fa.delete();
        send_bit(1'b0, 1'b0, 16);
        for (int i = 0; i < 4; i++) send_bit(1'b0, v[i], 16);
        send_bit(1'b0, v[4], 8);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (dout_a !== 8'h00 || done_a !== 1'b0) begin errors++;
            $display("FAIL rstmid_dout got=%h/%b exp=00/0", dout_a, done_a); end
        checks++; if (ferr_a !== 1'b0 || busy_a !== 1'b0) begin errors++;
            $display("FAIL rstmid_flags got=%b/%b exp=0/0", ferr_a, busy_a); end
        send_bit(1'b0, 1'b1, 100);
        checks++; if (qa.size() != 0) begin errors++;
            $display("FAIL rstmid_strobes got=%0d exp=0", qa.size()); end
        send_frame(1'b0, 9'h081, 8, 1'b1, 16);
        send_bit(1'b0, 1'b1, 8);
        @(negedge clk);
        d = (qa.size() > 0) ? qa[0] : 8'hxx;
        f = (fa.size() > 0) ? fa[0] : 1'bx;
        checks++; if (qa.size() != 1) begin errors++;
            $display("FAIL rstmid_next_strobes got=%0d exp=1", qa.size()); end
        checks++; if (d !== 8'h81 || f !== 1'b0) begin errors++;
            $display("FAIL rstmid_next got=%h/%b exp=81/0", d, f); end
    endtask

    task automatic test_dbit7;
        logic [6:0] d;
        logic       f;
        qb.delete(); fb.delete();
        send_frame(1'b1, 9'h055, 7, 1'b1, 32);
        send_bit(1'b1, 1'b1, 8);
        @(negedge clk);
        d = (qb.size() > 0) ? qb[0] : 7'hxx;
        f = (fb.size() > 0) ? fb[0] : 1'bx;
        checks++; if (qb.size() != 1) begin errors++;
            $display("FAIL d7_strobes got=%0d exp=1", qb.size()); end
        checks++; if (d !== 7'h55) begin errors++;
            $display("FAIL d7_dout got=%h exp=55", d); end
        checks++; if (f !== 1'b0 || busy_b !== 1'b0) begin errors++;
            $display("FAIL d7_flags got=%b/%b exp=0/0", f, busy_b); end
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_glitch();
        test_break();
        test_back_to_back();
        test_reset_midframe();
        test_dbit7();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
